// File: rtl/result_collector.sv
// Collects 2x2 PE results into a circular tile buffer and drains them one word per handshake.
// The sequencer checks the drain strobe order; done fires after the operation is fully drained.
module result_collector #(
    parameter int DW    = 32,
    parameter int TILES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          push11,
    input  logic          pushedge,
    input  logic          push22,
    input  logic [DW-1:0] c11,
    input  logic [DW-1:0] c12,
    input  logic [DW-1:0] c21,
    input  logic [DW-1:0] c22,
    input  logic          op_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [31:0]   out_tile,
    output logic          done,
    output logic          overflow,
    output logic          seq_err
);

    localparam int PW = $clog2(TILES);
    localparam logic [PW:0] FULL_CNT = TILES[PW:0];

    typedef enum logic [1:0] {WAIT11, WAITEDGE, WAIT22} seq_t;

    seq_t          state;
    logic          live;
    logic          pending_done;
    logic [DW-1:0] cap11, cap12, cap21;
    logic [DW-1:0] mem [TILES][4];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [1:0]    word_idx;

    logic [1:0] n_strobes;
    logic       do_step, multi, full, pop, tile_pop, commit_ok;

    always_comb begin
        do_step   = live && !start;
        n_strobes = 2'(push11) + 2'(pushedge) + 2'(push22);
        multi     = n_strobes > 2'd1;
        full      = count == FULL_CNT;
        out_valid = count != '0;
        pop       = out_valid && out_ready;
        tile_pop  = pop && (word_idx == 2'd3);
        commit_ok = do_step && !multi && push22 && (state == WAIT22) && !full;
        out_data  = out_valid ? mem[rd_ptr][word_idx] : '0;
        out_last  = out_valid && (word_idx == 2'd3);
    end

    // Data path carries no reset: count==0 masks whatever the storage holds.
    always_ff @(posedge clk) begin
        if (do_step && !multi) begin
            if (push11) cap11 <= c11;
            if (pushedge && state == WAITEDGE) begin
                cap12 <= c12;
                cap21 <= c21;
            end
        end
        if (commit_ok) begin
            mem[wr_ptr][0] <= cap11;
            mem[wr_ptr][1] <= cap12;
            mem[wr_ptr][2] <= cap21;
            mem[wr_ptr][3] <= c22;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live         <= 1'b0;
            state        <= WAIT11;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            word_idx     <= '0;
            out_tile     <= '0;
            done         <= 1'b0;
            pending_done <= 1'b0;
            overflow     <= 1'b0;
            seq_err      <= 1'b0;
        end else if (!live || start) begin
            // First edge after release and every flush do nothing but clear.
            live         <= 1'b1;
            state        <= WAIT11;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            word_idx     <= '0;
            out_tile     <= '0;
            done         <= 1'b0;
            pending_done <= 1'b0;
            overflow     <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            if (multi) begin
                seq_err <= 1'b1;
                state   <= WAIT11;
            end else if (push11) begin
                if (state != WAIT11) seq_err <= 1'b1;
                state <= WAITEDGE;
            end else if (pushedge) begin
                if (state == WAITEDGE) begin
                    state <= WAIT22;
                end else begin
                    seq_err <= 1'b1;
                    state   <= WAIT11;
                end
            end else if (push22) begin
                if (state != WAIT22) seq_err <= 1'b1;
                else if (full) overflow <= 1'b1;
                state <= WAIT11;
            end

            if (commit_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop) word_idx <= word_idx + 2'd1;
            if (tile_pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_tile <= out_tile + 32'd1;
            end
            count <= count + {{PW{1'b0}}, commit_ok} - {{PW{1'b0}}, tile_pop};

            done <= 1'b0;
            if (pending_done && count == '0 && state == WAIT11) begin
                done         <= 1'b1;
                pending_done <= 1'b0;
            end else if (op_valid) begin
                pending_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed table, hand sequences, and a random run
// compared every cycle against a queue-based reference model.
module tb_result_collector;

    localparam int DW    = 32;
    localparam int TILES = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          push11 = 1'b0, pushedge = 1'b0, push22 = 1'b0;
    logic [DW-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic          op_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [31:0]   out_tile;
    logic          done, overflow, seq_err;

    result_collector #(.DW(DW), .TILES(TILES)) dut (
        .clk(clk), .reset(reset), .start(start),
        .push11(push11), .pushedge(pushedge), .push22(push22),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .op_valid(op_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_tile(out_tile),
        .done(done), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tiles as 128-bit records in a queue, partial tile as a word list.
    typedef logic [4*DW-1:0] tile_t;
    tile_t         m_fifo[$];
    logic [DW-1:0] m_part[$];
    int            m_pos, m_tile;
    bit            m_live, m_ovf, m_err, m_pend, m_done;

    function automatic void m_clear();
        m_fifo.delete();
        m_part.delete();
        m_pos = 0; m_tile = 0;
        m_ovf = 0; m_err = 0; m_pend = 0; m_done = 0;
    endfunction

    function automatic void m_step(input logic [2:0] s, input logic [DW-1:0] w11, w12, w21, w22,
                                   input logic rdy, opv, st);
        bit was_full, was_empty;
        int n;
        if (!reset) begin m_clear(); m_live = 0; return; end
        if (!m_live) begin m_live = 1; return; end
        if (st) begin m_clear(); return; end
        was_full  = m_fifo.size() == TILES;
        was_empty = m_fifo.size() == 0;
        m_done = 0;
        if (m_pend && was_empty && m_part.size() == 0) begin m_done = 1; m_pend = 0; end
        else if (opv) m_pend = 1;
        if (!was_empty && rdy) begin
            m_pos++;
            if (m_pos == 4) begin void'(m_fifo.pop_front()); m_pos = 0; m_tile++; end
        end
        n = int'(s[2]) + int'(s[1]) + int'(s[0]);
        if (n > 1) begin
            m_err = 1; m_part.delete();
        end else if (s[2]) begin
            if (m_part.size() != 0) m_err = 1;
            m_part.delete(); m_part.push_back(w11);
        end else if (s[1]) begin
            if (m_part.size() == 1) begin m_part.push_back(w12); m_part.push_back(w21); end
            else begin m_err = 1; m_part.delete(); end
        end else if (s[0]) begin
            if (m_part.size() == 3) begin
                if (was_full) m_ovf = 1;
                else m_fifo.push_back({w22, m_part[2], m_part[1], m_part[0]});
            end else m_err = 1;
            m_part.delete();
        end
    endfunction

    task automatic m_compare();
        bit v;
        v = m_fifo.size() != 0;
        chk("m_valid", 32'(out_valid), 32'(v));
        chk("m_data", out_data, v ? m_fifo[0][m_pos*DW +: DW] : '0);
        chk("m_last", 32'(out_last), 32'(v && m_pos == 3));
        chk("m_tile", out_tile, m_tile);
        chk("m_done", 32'(done), 32'(m_done));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_seq_err", 32'(seq_err), 32'(m_err));
    endtask

    task automatic cyc(input logic [2:0] s, input logic [DW-1:0] w11, w12, w21, w22,
                       input logic rdy, opv, st);
        push11 = s[2]; pushedge = s[1]; push22 = s[0];
        c11 = w11; c12 = w12; c21 = w21; c22 = w22;
        out_ready = rdy; op_valid = opv; start = st;
        @(posedge clk);
        m_step(s, w11, w12, w21, w22, rdy, opv, st);
        #1;
        push11 = 0; pushedge = 0; push22 = 0; op_valid = 0; start = 0; out_ready = 0;
        m_compare();
    endtask

    task automatic idle(input logic rdy);
        cyc(3'b000, '0, '0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic triple(input logic [DW-1:0] b, input logic rdy);
        cyc(3'b100, b, '0, '0, '0, rdy, 1'b0, 1'b0);
        cyc(3'b010, '0, b + 1, b + 2, '0, rdy, 1'b0, 1'b0);
        cyc(3'b001, '0, '0, '0, b + 3, rdy, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  s;
        int          a;
        int          b;
        logic        ev;
        int          ed;
        logic        el;
        int          et;
        logic        ee;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int r, g, hs_edge, done_edge, done_cnt;
        logic [2:0] s;
        logic rdy, opv, st;

        tbl[0]  = '{3'b100,   5, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{3'b010,  -3, 7, 0,   0, 0, 0, 0};
        tbl[2]  = '{3'b001, 100, 0, 1,   5, 0, 0, 0};
        tbl[3]  = '{3'b000,   0, 0, 1,  -3, 0, 0, 0};
        tbl[4]  = '{3'b000,   0, 0, 1,   7, 0, 0, 0};
        tbl[5]  = '{3'b000,   0, 0, 1, 100, 1, 0, 0};
        tbl[6]  = '{3'b000,   0, 0, 0,   0, 0, 1, 0};
        tbl[7]  = '{3'b010,   1, 2, 0,   0, 0, 1, 1};
        tbl[8]  = '{3'b100,  11, 0, 0,   0, 0, 1, 1};
        tbl[9]  = '{3'b010,  12, 21, 0,  0, 0, 1, 1};
        tbl[10] = '{3'b001,  22, 0, 1,  11, 0, 1, 1};
        tbl[11] = '{3'b000,   0, 0, 1,  12, 0, 1, 1};
        tbl[12] = '{3'b000,   0, 0, 1,  21, 0, 1, 1};
        tbl[13] = '{3'b000,   0, 0, 1,  22, 1, 1, 1};
        tbl[14] = '{3'b000,   0, 0, 0,   0, 0, 2, 1};

        m_clear(); m_live = 0;
        #1 reset = 0;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_tile", out_tile, 0);
        chk("rst_flags", {29'd0, done, overflow, seq_err}, 0);
        idle(1); idle(1);
        reset = 1;
        idle(1);

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].a, tbl[i].b, tbl[i].a, 1'b1, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_last", i), 32'(out_last), 32'(tbl[i].el));
            chk($sformatf("tbl%0d_tile", i), out_tile, tbl[i].et);
            chk($sformatf("tbl%0d_seq_err", i), 32'(seq_err), 32'(tbl[i].ee));
        end

        // Backpressure and overflow with two tiles held.
        cyc(3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        triple(1, 0); triple(5, 0);
        for (int k = 0; k < 3; k++) begin
            idle(0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", out_data, 1);
        end
        triple(9, 0);
        chk("bp_overflow", 32'(overflow), 1);
        for (int k = 0; k < 8; k++) begin
            chk("bp_drain_data", out_data, k + 1);
            chk("bp_drain_tile", out_tile, k / 4);
            idle(1);
        end
        chk("bp_empty", 32'(out_valid), 0);
        chk("bp_tile_end", out_tile, 2);

        // Commit on the same edge as the c22 pop of the only buffered tile.
        cyc(3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        triple(21, 0);
        cyc(3'b100, 31, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(3'b010, '0, 32, 33, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(3'b001, '0, '0, '0, 34, 1'b1, 1'b0, 1'b0);
        chk("cc_overflow", 32'(overflow), 0);
        chk("cc_valid", 32'(out_valid), 1);
        chk("cc_data", out_data, 31);
        chk("cc_tile", out_tile, 1);

        // Four-tile operation, op_valid with two tiles still buffered.
        cyc(3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        triple(100, 0); triple(200, 0);
        idle(1); idle(1);
        cyc(3'b100, 300, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(3'b010, '0, 301, 302, '0, 1'b1, 1'b0, 1'b0);
        cyc(3'b001, '0, '0, '0, 303, 1'b1, 1'b0, 1'b0);
        cyc(3'b100, 400, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(3'b010, '0, 401, 402, '0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(3'b001, '0, '0, '0, 403, 1'b1, 1'b0, 1'b0);
        chk("dn_overflow", 32'(overflow), 0);
        cyc(3'b000, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        hs_edge = -100; done_edge = -1; done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_last) hs_edge = k;
            idle(1);
            if (done) begin done_cnt++; done_edge = k; end
        end
        chk("dn_pulses", done_cnt, 1);
        chk("dn_timing", done_edge, hs_edge + 1);
        chk("dn_tile", out_tile, 4);

        // Asynchronous reset in the middle of a tile drain.
        cyc(3'b000, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        triple(41, 0);
        cyc(3'b000, '0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("rm_pre_data", out_data, 43);
        reset = 0;
        m_clear(); m_live = 0;
        #2;
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_data", out_data, 0);
        chk("rm_last", 32'(out_last), 0);
        chk("rm_done", 32'(done), 0);
        idle(1);
        reset = 1;
        for (int k = 0; k < 10; k++) idle(1);

        // Randomized run against the model.
        g = 0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            s = 3'b000;
            if (r < 50) s = (g == 0) ? 3'b100 : (g == 1) ? 3'b010 : 3'b001;
            else if (r < 55) s = 3'b100 >> $urandom_range(0, 2);
            else if (r < 57) s = 3'b111 ^ (3'b100 >> $urandom_range(0, 2));
            if (s == 3'b100) g = 1;
            else if (s == 3'b010) g = (g == 1) ? 2 : 0;
            else if (s != 3'b000) g = 0;
            st = $urandom_range(0, 99) == 0;
            if (st) g = 0;
            opv = $urandom_range(0, 99) < 3;
            rdy = $urandom_range(0, 99) < 55;
            cyc(s, $urandom, $urandom, $urandom, $urandom, rdy, opv, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
